// File: rtl/nn_pkg.sv
// Shared fixed-point definitions for the neuron datapath and the sigmoid stage.
// fx_t is the Q6.10 activation format exchanged between the two.
package nn_pkg;

  localparam int DATA_W = 17;
  localparam int FRAC_W = 10;

  typedef logic signed [DATA_W-1:0] fx_t;

  typedef enum logic [1:0] {
    ACC,
    FINAL,
    OUT
  } state_e;

  localparam fx_t FX_MAX = fx_t'((2 ** (DATA_W - 1)) - 1);
  localparam fx_t FX_MIN = fx_t'(-(2 ** (DATA_W - 1)));

  // Sigmoid breakpoints: saturates beyond +/-7.0, midpoint output 0.5.
  localparam fx_t SIG_POS_LIM = fx_t'(7 << FRAC_W);
  localparam fx_t SIG_NEG_LIM = fx_t'(-(7 << FRAC_W));
  localparam fx_t SIG_HALF    = fx_t'(1 << (FRAC_W - 1));

endpackage

// File: rtl/fx_round_sat.sv
// Round-half-up and saturate a wide fixed-point value (FRAC_W extra fraction
// bits) down to a DATA_W fixed-point word. Purely combinational.
module fx_round_sat #(
  parameter int IN_W   = 44,
  parameter int DATA_W = nn_pkg::DATA_W,
  parameter int FRAC_W = nn_pkg::FRAC_W
) (
  input  logic signed [IN_W-1:0]   din,
  output logic signed [DATA_W-1:0] dout,
  output logic                     sat
);

  // One guard bit above IN_W so adding the half-LSB can never wrap.
  localparam logic signed [IN_W:0] HALF    = (IN_W + 1)'(1) << (FRAC_W - 1);
  localparam logic signed [IN_W:0] LIM_MAX = {{(IN_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [IN_W:0] LIM_MIN = {{(IN_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

  logic signed [IN_W:0] biased;
  logic signed [IN_W:0] r;

  assign biased = $signed({din[IN_W-1], din}) + HALF;
  assign r      = biased >>> FRAC_W;

  always_comb begin
    dout = r[DATA_W-1:0];
    sat  = 1'b0;
    if (r > LIM_MAX) begin
      dout = LIM_MAX[DATA_W-1:0];
      sat  = 1'b1;
    end else if (r < LIM_MIN) begin
      dout = LIM_MIN[DATA_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Serial multiply-accumulate for one neuron pre-activation: NUM_INPUTS beats of
// in_x*in_w, plus bias, rounded/saturated to fx and offered on a valid/ready port.
module neuron_mac #(
  parameter int DATA_W     = nn_pkg::DATA_W,
  parameter int FRAC_W     = nn_pkg::FRAC_W,
  parameter int NUM_INPUTS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_w,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_x,
  output logic                     out_sat
);

  import nn_pkg::*;

  // Sized so NUM_INPUTS full-scale products plus bias cannot overflow.
  localparam int ACC_W = 2 * DATA_W + $clog2(NUM_INPUTS) + 1;
  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      in_ready_q, in_ready_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0]  out_x_q, out_x_d;
  logic                      out_sat_q, out_sat_d;

  logic                      accept;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   bias_sh;
  logic signed [ACC_W-1:0]   sum;
  logic signed [DATA_W-1:0]  rs_x;
  logic                      rs_sat;

  assign accept   = in_valid && in_ready_q;
  assign prod     = in_x * in_w;
  assign acc_base = (count_q == '0) ? '0 : acc_q;
  assign bias_sh  = ACC_W'(bias) <<< FRAC_W;
  assign sum      = acc_q + bias_sh;

  fx_round_sat #(
    .IN_W  (ACC_W),
    .DATA_W(DATA_W),
    .FRAC_W(FRAC_W)
  ) u_round_sat (
    .din (sum),
    .dout(rs_x),
    .sat (rs_sat)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_sat_d   = out_sat_q;
    unique case (state_q)
      ACC: begin
        if (accept) begin
          acc_d = acc_base + ACC_W'(prod);
          if (count_q == LAST) begin
            count_d    = '0;
            state_d    = FINAL;
            in_ready_d = 1'b0;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      FINAL: begin
        out_x_d     = rs_x;
        out_sat_d   = rs_sat;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        // in_ready comes back from a flop, never straight from out_ready.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ACC;
        end
      end
      default: begin
        state_d     = ACC;
        count_d     = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      count_q     <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac (NUM_INPUTS=4, Q6.10): hand-computed vectors,
// stall/gap handshake, reset mid-neuron, and 100 randomised neurons vs a model.
module tb_neuron_mac;

  localparam int DW = 17;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic signed [DW-1:0] in_x = '0;
  logic signed [DW-1:0] in_w = '0;
  logic signed [DW-1:0] bias = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic                 out_sat;
  logic signed [DW-1:0] out_x;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [DW-1:0] vx [4];
  logic signed [DW-1:0] vw [4];

  always #5 clk = ~clk;

  neuron_mac #(
    .DATA_W    (17),
    .FRAC_W    (10),
    .NUM_INPUTS(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_w     (in_w),
    .bias     (bias),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_x    (out_x),
    .out_sat  (out_sat)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_all(input logic signed [DW-1:0] x, input logic signed [DW-1:0] w);
    for (int i = 0; i < 4; i++) begin
      vx[i] = x;
      vw[i] = w;
    end
  endtask

  // Starts and ends at a negedge; leaves in_valid high for back-to-back beats.
  task automatic beat(input logic signed [DW-1:0] x, input logic signed [DW-1:0] w);
    in_x     = x;
    in_w     = w;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) break;
      @(posedge clk);
      @(negedge clk);
    end
    if (!in_ready) chk("beat_timeout_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic neuron(input logic signed [DW-1:0] b, input int gap_max, input int stall,
                        input string tag);
    longint               s;
    longint               r;
    logic signed [DW-1:0] ex;
    logic                 es;
    int                   g;
    s = 0;
    for (int i = 0; i < 4; i++) s += longint'(vx[i]) * longint'(vw[i]);
    s += longint'(b) * 1024;
    r  = (s + 512) >>> 10;
    es = 1'b0;
    if (r > 65535) begin
      r  = 65535;
      es = 1'b1;
    end else if (r < -65536) begin
      r  = -65536;
      es = 1'b1;
    end
    ex = DW'(r);

    bias = b;
    for (int i = 0; i < 4; i++) begin
      if (gap_max > 0) begin
        g        = int'($urandom_range(0, gap_max));
        in_valid = 1'b0;
        repeat (g) begin
          @(posedge clk);
          @(negedge clk);
        end
      end
      beat(vx[i], vw[i]);
    end
    in_valid  = 1'b0;
    out_ready = (stall == 0);
    chk({tag, "_final_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_final_out_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_out_x"}, out_x, ex);
    chk({tag, "_out_sat"}, 64'(out_sat), 64'(es));
    chk({tag, "_out_in_ready"}, 64'(in_ready), 64'd0);
    repeat (stall) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_stall_x"}, out_x, ex);
      chk({tag, "_stall_sat"}, 64'(out_sat), 64'(es));
      chk({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_done_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_x", out_x, 64'sd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    set_all(17'sd1024, 17'sd1024);
    neuron(17'sd0, 0, 0, "nominal");
    chk("nominal_value", out_x, 64'sd4096);

    set_all(-17'sd1024, 17'sd2048);
    neuron(17'sd1024, 0, 0, "bias_sign");
    chk("bias_sign_value", out_x, -64'sd7168);

    set_all(17'sd0, 17'sd0);
    vx[0] = 17'sd1; vw[0] = 17'sd512;
    neuron(17'sd0, 0, 0, "round_up");
    chk("round_up_value", out_x, 64'sd1);
    vw[0] = 17'sd511;
    neuron(17'sd0, 0, 0, "round_down");
    chk("round_down_value", out_x, 64'sd0);
    vx[0] = -17'sd1; vw[0] = 17'sd512;
    neuron(17'sd0, 0, 0, "round_neg_half");
    chk("round_neg_half_value", out_x, 64'sd0);

    set_all(17'sd16384, 17'sd16384);
    neuron(17'sd0, 0, 0, "sat_pos");
    chk("sat_pos_value", out_x, 64'sd65535);
    chk("sat_pos_flag", 64'(out_sat), 64'd1);
    set_all(17'sd16384, -17'sd16384);
    neuron(17'sd0, 0, 0, "sat_neg");
    chk("sat_neg_value", out_x, -64'sd65536);
    chk("sat_neg_flag", 64'(out_sat), 64'd1);

    set_all(17'sd1536, -17'sd512);
    neuron(17'sd300, 2, 3, "stall3");

    // Reset after two of four beats: partial sum must vanish.
    set_all(17'sd1024, 17'sd1024);
    beat(17'sd3000, 17'sd3000);
    beat(17'sd3000, 17'sd3000);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_x", out_x, 64'sd0);
    chk("midrst_out_sat", 64'(out_sat), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    neuron(17'sd0, 0, 0, "post_rst");
    chk("post_rst_value", out_x, 64'sd4096);

    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 4; i++) begin
        vx[i] = DW'(int'($urandom_range(0, 16383)) - 8192);
        vw[i] = DW'(int'($urandom_range(0, 16383)) - 8192);
      end
      neuron(DW'(int'($urandom_range(0, 8191)) - 4096), 2, int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Upstream feeder of the sigmoid activation stage: computes one neuron pre-activation, x = sum(in_x[i]*in_w[i]) + bias, over NUM_INPUTS serial beats.
- Rounds and saturates the result back to the activation input format, then presents it with a valid/ready handshake.
- All data is signed two's-complement fixed point, Q6.10 by default (17 bits), matching the activation input width.

Parameters:
- DATA_W, 17, width of in_x, in_w, bias and out_x.
- FRAC_W, 10, fractional bits of every DATA_W operand.
- NUM_INPUTS, 4, beats per neuron; legal range 1..1024.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_x/in_w beat valid.
- in_ready  output  1  block accepts a beat.
- in_x  input  DATA_W  signed activation operand.
- in_w  input  DATA_W  signed weight operand.
- bias  input  DATA_W  signed bias; sampled in FINAL state only.
- out_valid  output  1  out_x valid.
- out_ready  input  1  downstream (sigmoid) accepts.
- out_x  output  DATA_W  rounded, saturated pre-activation.
- out_sat  output  1  out_x was clamped; qualified by out_valid.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst_n is asynchronous, active-low.
- Reset values: state=ACC, count=0, acc=0, in_ready=1, out_valid=0, out_x=0, out_sat=0.
- Widths:
  - Product is 2*DATA_W signed with 2*FRAC_W fractional bits.
  - Accumulator ACC_W = 2*DATA_W + clog2(NUM_INPUTS) + 1 bits; it never overflows internally.
- State machine: ACC -> FINAL -> OUT -> ACC.
- ACC:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - On acceptance, acc <= (count==0 ? 0 : acc) + in_x*in_w, and count increments.
  - On the beat where count==NUM_INPUTS-1: count <= 0, go to FINAL.
  - No beat accepted means acc and count hold. Gaps between beats are legal.
- FINAL, one cycle:
  - in_ready=0.
  - sum = acc + (sign-extended bias << FRAC_W).
  - Round half-up: r = (sum + 2^(FRAC_W-1)) >>> FRAC_W, arithmetic shift.
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; out_sat=1 if clamped.
  - Register out_x and out_sat, set out_valid=1, go to OUT.
- OUT:
  - in_ready=0.
  - out_valid, out_x and out_sat hold stable until out_ready=1.
  - On the handshake cycle: out_valid <= 0, go to ACC.
  - No combinational path from out_ready to in_ready.
- Latency: last beat accepted at edge t -> out_valid high after edge t+1. Minimum 2 idle-input cycles per neuron.
- Throughput: one neuron per NUM_INPUTS+2 cycles when out_ready is held at 1.
- NUM_INPUTS=1: every accepted beat goes straight to FINAL.
- Reset mid-operation: partial acc and any pending output are discarded. Post-reset state equals the reset values; the first beat after reset starts a new neuron.
- in_valid during FINAL/OUT is ignored (in_ready=0). Upstream must hold the beat until accepted.
- bias must be stable from the last accepted beat through FINAL.

Decomposition:
- Shared package nn_pkg: DATA_W=17, FRAC_W=10 constants; signed fixed-point typedef fx_t; state enum {ACC, FINAL, OUT}; saturation bounds FX_MAX/FX_MIN.
- These same constants are consumed by the sigmoid stage, so its thresholds ±7 and 0.5 are expressed in fx_t.
- One natural sub-module: fx_round_sat. It is combinational: ACC_W-bit input -> DATA_W out plus sat flag. It is reusable by later layers.

Test Plan:
- Nominal, NUM_INPUTS=4: four beats in_x=1024, in_w=1024 (1.0*1.0), bias=0 -> out_x=4096 (4.0), out_sat=0, out_valid one cycle after edge t+1.
- Bias and sign: four beats in_x=-1024, in_w=2048, bias=1024 -> out_x=-7168 (-7.0), out_sat=0.
- Rounding: one beat in_x=1, in_w=512, three beats of 0, bias=0 -> out_x=1. Repeat with in_w=511 -> out_x=0. Repeat with in_x=-1, in_w=512 -> out_x=0.
- Saturation: four beats in_x=in_w=16384 -> out_x=65535, out_sat=1. Four beats in_x=16384, in_w=-16384 -> out_x=-65536, out_sat=1.
- Handshake stress:
  - Random in_valid gaps, plus out_ready low for 3 cycles in OUT.
  - Required: out_x/out_valid stable while stalled, in_ready=0 in FINAL/OUT, no beat lost or duplicated over 100 back-to-back neurons against a reference model.
- Reset mid-neuron: assert rst_n=0 after 2 of 4 beats -> all outputs at reset values immediately. A fresh 4-beat neuron then yields only its own result.
